// File: rtl/lot_draw_tx_pkg.sv
// Shared definitions for the lottery-core transmit driver (lot_draw_tx).
// Contents:
//   lot_tx_state_t - playback FSM states
//   lot_digit_t    - 4-bit BCD digit, bit 0 is the MSB to match the core's num[0:3]
//   LOT_BCD_MAX    - largest legal digit value
//   LOT_LFSR_SEED / LOT_LFSR_TAPS - reset value and feedback mask of the draw LFSR
//   lot_fold_bcd() - folds a 4-bit value into 0..9
package lot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP,
    ST_FIM,
    ST_FIMJ
  } lot_tx_state_t;

  typedef logic [0:3] lot_digit_t;

  localparam lot_digit_t LOT_BCD_MAX = 4'd9;

  // x^8 + x^6 + x^5 + x^4 + 1 : feedback from bits 7, 5, 4, 3 of a left-shifting register.
  localparam logic [7:0] LOT_LFSR_SEED = 8'hA5;
  localparam logic [7:0] LOT_LFSR_TAPS = 8'hB8;

  // 10..15 map to 4..9 so every nibble gives a legal digit.
  function automatic lot_digit_t lot_fold_bcd(input logic [3:0] n);
    return (n > 4'd9) ? lot_digit_t'(n - 4'd6) : lot_digit_t'(n);
  endfunction

endpackage

// File: rtl/lot_draw_tx_if.sv
// Loader/core-side bundle of lot_draw_tx.
//   master : loader side   - drives load, load_data, start; observes the rest
//   slave  : lot_draw_tx   - consumes load/start, drives num, insere, fim,
//                            fim_jogo, busy, done, err
interface lot_draw_tx_if;
  import lot_pkg::*;

  logic       load;
  lot_digit_t load_data;
  logic       start;
  lot_digit_t num;
  logic       insere;
  logic       fim;
  logic       fim_jogo;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output load, load_data, start,
    input  num, insere, fim, fim_jogo, busy, done, err
  );

  modport slave (
    input  load, load_data, start,
    output num, insere, fim, fim_jogo, busy, done, err
  );

endinterface

// File: rtl/lot_lfsr8.sv
// 8-bit Fibonacci LFSR used as the random draw source of lot_draw_tx.
// Ports:
//   clk   - rising-edge clock; the register advances every cycle
//   reset - synchronous, active-low; loads LOT_LFSR_SEED
//   q     - current register value
module lot_lfsr8
  import lot_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] q
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= LOT_LFSR_SEED;
    end else begin
      q <= {q[6:0], ^(q & LOT_LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/lot_draw_tx.sv
// Transmit driver for the lottery core's number-entry inputs. Buffers a full
// draw of BCD digits and plays it out as insere / fim / fim_jogo strobes,
// each followed by GAP idle cycles.
// Ports:
//   clk   - sole clock, rising edge
//   reset - synchronous, active-low
//   bus   - lot_draw_tx_if.slave: load, load_data, start in;
//           num, insere, fim, fim_jogo, busy, done, err out (all registered)
// Optional feature: define LOT_DRAW_LFSR_EN to play a pseudo-random draw
// when start arrives with an empty buffer (instantiates lot_lfsr8).
module lot_draw_tx
  import lot_pkg::*;
#(
  parameter int PLAYERS         = 2,
  parameter int NUMS_PER_PLAYER = 5,
  parameter int GAP             = 3
) (
  input logic          clk,
  input logic          reset,
  lot_draw_tx_if.slave bus
);

  localparam int DEPTH = PLAYERS * NUMS_PER_PLAYER;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int DW    = $clog2(NUMS_PER_PLAYER + 1);

  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [DW-1:0] LAST_DIG = DW'(NUMS_PER_PLAYER);
  localparam logic [3:0]    GAP_LOAD = 4'(GAP - 1);

  lot_tx_state_t state;
  logic [CW-1:0] cnt;       // digits written
  logic [CW-1:0] idx;       // digits sent this game
  logic [DW-1:0] dig;       // digits sent for the current player
  logic [3:0]    gcnt;      // remaining gap cycles minus one
  logic          fim_sent;  // the running gap follows a fim strobe
  lot_digit_t    mem [DEPTH];

  lot_digit_t next_digit;
  logic       start_empty;
  logic       load_ok;
  logic       start_ok;
  logic       go_send;

`ifdef LOT_DRAW_LFSR_EN
  logic [7:0] lfsr_q;
  logic       rnd;          // current game plays from the LFSR

  lot_lfsr8 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr_q)
  );

  assign start_empty = (cnt == '0);
  // In IDLE the game has not begun, so the source is chosen from cnt directly.
  assign next_digit  = ((state == ST_IDLE) ? start_empty : rnd)
                       ? lot_fold_bcd(lfsr_q[3:0]) : mem[idx];
`else
  assign start_empty = 1'b0;
  assign next_digit  = mem[idx];
`endif

  assign load_ok  = (state == ST_IDLE) && bus.load &&
                    (bus.load_data <= LOT_BCD_MAX) && (cnt != FULL);
  assign start_ok = (cnt == FULL) || start_empty;

  // Every entry into SEND: from IDLE on an accepted start, or at the end of a
  // gap when either this player has digits left or another player follows.
  assign go_send = ((state == ST_IDLE) && bus.start && start_ok) ||
                   ((state == ST_GAP) && (gcnt == '0) &&
                    (fim_sent ? (idx != FULL) : (dig != LAST_DIG)));

  // NOTE: the digit store has no reset; cnt alone marks which entries are valid.
  always_ff @(posedge clk) begin
    if (load_ok) begin
      mem[cnt] <= bus.load_data;
    end
  end

  // NOTE: non-blocking assignments throughout, so later assignments in this
  // block override the defaults above them within the same edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      idx          <= '0;
      dig          <= '0;
      gcnt         <= '0;
      fim_sent     <= 1'b0;
      bus.num      <= '0;
      bus.insere   <= 1'b0;
      bus.fim      <= 1'b0;
      bus.fim_jogo <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.err      <= 1'b0;
`ifdef LOT_DRAW_LFSR_EN
      rnd          <= 1'b0;
`endif
    end else begin
      bus.insere   <= 1'b0;
      bus.fim      <= 1'b0;
      bus.fim_jogo <= 1'b0;
      bus.done     <= 1'b0;

      if ((state != ST_IDLE) && bus.load) begin
        bus.err <= 1'b1;
      end

      unique case (state)
        ST_IDLE: begin
          // start is judged on the pre-load cnt; a rejected load written
          // after it keeps err set.
          if (bus.start) begin
            if (start_ok) begin
              bus.busy <= 1'b1;
              bus.err  <= 1'b0;
`ifdef LOT_DRAW_LFSR_EN
              rnd      <= start_empty;
`endif
            end else begin
              bus.err <= 1'b1;
            end
          end
          if (bus.load) begin
            if (load_ok) begin
              cnt <= cnt + 1'b1;
            end else begin
              bus.err <= 1'b1;
            end
          end
        end
        ST_SEND: begin
          state    <= ST_GAP;
          gcnt     <= GAP_LOAD;
          fim_sent <= 1'b0;
        end
        ST_GAP: begin
          if (gcnt != '0) begin
            gcnt <= gcnt - 1'b1;
          end else if (fim_sent && (idx == FULL)) begin
            state        <= ST_FIMJ;
            bus.fim_jogo <= 1'b1;
            bus.done     <= 1'b1;
          end else if (!fim_sent && (dig == LAST_DIG)) begin
            state   <= ST_FIM;
            bus.fim <= 1'b1;
          end
        end
        ST_FIM: begin
          state    <= ST_GAP;
          gcnt     <= GAP_LOAD;
          fim_sent <= 1'b1;
        end
        ST_FIMJ: begin
          state    <= ST_IDLE;
          bus.busy <= 1'b0;
          cnt      <= '0;
          idx      <= '0;
        end
        default: state <= ST_IDLE;
      endcase

      if (go_send) begin
        state      <= ST_SEND;
        bus.insere <= 1'b1;
        bus.num    <= next_digit;
        idx        <= idx + 1'b1;
        dig        <= ((state == ST_IDLE) || fim_sent) ? DW'(1) : dig + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lot_draw_tx.sv
// Self-checking bench for lot_draw_tx: directed scenarios with literal
// expectations, then randomized traffic, all compared every cycle against a
// timeline model of the playback schedule.
module tb_lot_draw_tx;
  import lot_pkg::*;

  localparam int P      = 2;
  localparam int N      = 5;
  localparam int G      = 3;
  localparam int DEPTH  = P * N;
  localparam int PERIOD = G + 1;
  localparam int SLOTS  = P * (N + 1);       // digit and fim strobes
  localparam int LAST_K = PERIOD * SLOTS + 1; // cycle offset of fim_jogo

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  lot_draw_tx_if bus ();

  lot_draw_tx #(
    .PLAYERS         (P),
    .NUMS_PER_PLAYER (N),
    .GAP             (G)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Playback is a timeline: k cycles after the accepted start, a strobe is due
  // when (k-1) is a multiple of PERIOD; slot (k-1)/PERIOD selects what it is.
  int m_cnt, m_k, m_num;
  int m_mem [DEPTH];
  bit m_play, m_err, m_rnd;
  bit e_ins, e_fim, e_fj;
  int pre, s;

  always @(posedge clk) begin
    if (!reset) begin
      m_play = 0; m_k = 0; m_cnt = 0; m_err = 0; m_num = 0; m_rnd = 0;
    end else if (m_play) begin
      if (bus.load) m_err = 1;
      m_k++;
      if (m_k > LAST_K) begin
        m_play = 0;
        m_cnt  = 0;
      end
    end else begin
      pre = m_cnt;
      if (bus.start) begin
        if (pre == DEPTH) begin
          m_play = 1; m_k = 1; m_err = 0; m_rnd = 0;
`ifdef LOT_DRAW_LFSR_EN
        end else if (pre == 0) begin
          m_play = 1; m_k = 1; m_err = 0; m_rnd = 1;
`endif
        end else begin
          m_err = 1;
        end
      end
      if (bus.load) begin
        if (int'(bus.load_data) > 9 || m_cnt == DEPTH) m_err = 1;
        else begin
          m_mem[m_cnt] = int'(bus.load_data);
          m_cnt++;
        end
      end
    end
    e_ins = 0; e_fim = 0; e_fj = 0;
    if (m_play && ((m_k - 1) % PERIOD == 0)) begin
      s = (m_k - 1) / PERIOD;
      if (s == SLOTS) e_fj = 1;
      else if (s % (N + 1) < N) begin
        e_ins = 1;
        if (!m_rnd) m_num = m_mem[(s / (N + 1)) * N + s % (N + 1)];
      end else e_fim = 1;
    end
  end

  always @(negedge clk) begin
    check("insere", int'(bus.insere), int'(e_ins));
    check("fim", int'(bus.fim), int'(e_fim));
    check("fim_jogo", int'(bus.fim_jogo), int'(e_fj));
    check("done", int'(bus.done), int'(e_fj));
    check("busy", int'(bus.busy), int'(m_play));
    check("err", int'(bus.err), int'(m_err));
    if (m_rnd) check("num_is_bcd", int'(bus.num <= 4'd9), 1);
    else       check("num", int'(bus.num), m_num);
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit ld, input int d, input bit st);
    @(negedge clk);
    bus.load      = ld;
    bus.load_data = 4'(d);
    bus.start     = st;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0);
  endtask

  int pi_digits [DEPTH] = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3};
  int ins_at    [DEPTH] = '{1, 5, 9, 13, 17, 25, 29, 33, 37, 41};
  int seen_ins [60], seen_fim [60], seen_fj [60], seen_done [60], seen_busy [60], seen_num [60];

  initial begin
    bus.load = 0; bus.load_data = '0; bus.start = 0;
    repeat (3) @(negedge clk);
    check("reset_num", int'(bus.num), 0);
    check("reset_busy", int'(bus.busy), 0);
    reset = 1;

    // Known draw, literal timeline.
    for (int i = 0; i < DEPTH; i++) drive(1, pi_digits[i], 0);
    drive(0, 0, 1);
    for (int k = 1; k <= 52; k++) begin
      drive(0, 0, 0);
      seen_ins[k]  = int'(bus.insere);
      seen_fim[k]  = int'(bus.fim);
      seen_fj[k]   = int'(bus.fim_jogo);
      seen_done[k] = int'(bus.done);
      seen_busy[k] = int'(bus.busy);
      seen_num[k]  = int'(bus.num);
    end
    for (int i = 0; i < DEPTH; i++) begin
      check("lit_insere_slot", seen_ins[ins_at[i]], 1);
      check("lit_digit", seen_num[ins_at[i]], pi_digits[i]);
    end
    check("lit_no_insere_t2", seen_ins[2], 0);
    check("lit_fim_p1", seen_fim[21], 1);
    check("lit_fim_p2", seen_fim[45], 1);
    check("lit_fim_jogo", seen_fj[49], 1);
    check("lit_done", seen_done[49], 1);
    check("lit_busy_t1", seen_busy[1], 1);
    check("lit_busy_t49", seen_busy[49], 1);
    check("lit_busy_t50", seen_busy[50], 0);
    check("lit_num_hold", seen_num[50], 3);
    check("lit_err", int'(bus.err), 0);

    // Illegal digit, partial start, overflow, then recovery.
    drive(1, 12, 0); idle(1);
    check("lit_err_bad_digit", int'(bus.err), 1);
    for (int i = 0; i < 4; i++) drive(1, i + 2, 0);
    drive(0, 0, 1); idle(1);
    check("lit_partial_idle", int'(bus.busy), 0);
    check("lit_partial_err", int'(bus.err), 1);
    for (int i = 0; i < 6; i++) drive(1, 9 - i, 0);
    drive(1, 7, 0); idle(1);
    check("lit_overflow_err", int'(bus.err), 1);
    drive(0, 0, 1); idle(1);
    check("lit_start_clears_err", int'(bus.err), 0);
    idle(20);
    drive(1, 2, 1);          // ignored while busy, flags err
    idle(30);

    // Reset mid-playback, then clean replay.
    for (int i = 0; i < DEPTH; i++) drive(1, $urandom_range(0, 9), 0);
    drive(0, 0, 1);
    idle(22);
    @(negedge clk); reset = 0;
    idle(1);
    check("lit_rst_insere", int'(bus.insere), 0);
    check("lit_rst_busy", int'(bus.busy), 0);
    check("lit_rst_num", int'(bus.num), 0);
    @(negedge clk); reset = 1;
    for (int i = 0; i < DEPTH; i++) drive(1, $urandom_range(0, 9), 0);
    drive(0, 0, 1);
    idle(55);

`ifdef LOT_DRAW_LFSR_EN
    begin
      int n_ins;
      n_ins = 0;
      drive(0, 0, 1);
      for (int k = 0; k < 55; k++) begin
        drive(0, 0, 0);
        n_ins += int'(bus.insere);
      end
      check("lfsr_insere_count", n_ins, DEPTH);
    end
`endif

    // Randomized traffic.
    repeat (4000) begin
      bit ld, st;
      int d;
      ld = ($urandom_range(0, 99) < 40);
      st = ($urandom_range(0, 99) < 4);
      d  = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
      if (!m_play && m_cnt == DEPTH && ld && st) ld = 0;
      drive(ld, d, st);
      reset = ($urandom_range(0, 599) != 0);
    end
    reset = 1;
    idle(60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
